i2c_reg_target: RTL



---
 rtl/i2c_reg_target.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_reg_target.sv
// i2c_reg_target: I2C target front end for a byte-wide register bank.
// Decodes START/STOP, matches a 7-bit address, keeps an auto-incrementing
// register pointer and ACKs/NACKs bytes on the shared open-drain bus.
//
// Ports:
//   clk       system clock, at least 8x the SCL rate
//   rst       asynchronous active-high reset
//   scl_in    SCL pin level (asynchronous)
//   sda_in    SDA pin level (asynchronous)
//   sda_oe    1 = pull SDA low, 0 = release
//   reg_addr  current register pointer
//   wr_data   write byte, valid while wr_stb = 1
//   wr_stb    one-clk write strobe to reg_addr
//   rd_data   contents of register reg_addr
//   busy      1 while an addressed transaction is in progress
module i2c_reg_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] wr_data,
  output logic       wr_stb,
  input  logic [7:0] rd_data,
  output logic       busy
);

  typedef enum logic [3:0] {
    StIdle     = 4'd0,
    StAddr     = 4'd1,
    StAddrAck  = 4'd2,
    StPtr      = 4'd3,
    StPtrAck   = 4'd4,
    StWdata    = 4'd5,
    StWdataAck = 4'd6,
    StRdata    = 4'd7,
    StRdataAck = 4'd8,
    StWaitStop = 4'd9
  } state_e;

  // Synchronizers and edge detectors. Reset to 1 to match an idle bus so
  // leaving reset does not fabricate an edge.
  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_prev_q, sda_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_in};
      sda_sync_q <= {sda_sync_q[0], sda_in};
      scl_prev_q <= scl_sync_q[1];
      sda_prev_q <= sda_sync_q[1];
    end
  end

  logic scl_s, sda_s;
  logic scl_rise, scl_fall, start_det, stop_det;

  assign scl_s     = scl_sync_q[1];
  assign sda_s     = sda_sync_q[1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  // SCL must be high on both sides of the SDA edge to count as a condition.
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] sr_q, sr_d;
  logic       rw_q, rw_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] reg_addr_q, reg_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       wr_stb_q, wr_stb_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= 3'd0;
      sr_q       <= 8'h00;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      reg_addr_q <= 8'h00;
      wr_data_q  <= 8'h00;
      wr_stb_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      rw_q       <= rw_d;
      sda_oe_q   <= sda_oe_d;
      reg_addr_q <= reg_addr_d;
      wr_data_q  <= wr_data_d;
      wr_stb_q   <= wr_stb_d;
    end
  end

  logic [7:0] byte_in;
  logic       addr_match;

  assign byte_in    = {sr_q[6:0], sda_s};
  // Address 0 is the general call and is never answered.
  assign addr_match = (byte_in[7:1] == TARGET_ADDR) && (TARGET_ADDR != 7'h00);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    rw_d       = rw_q;
    sda_oe_d   = sda_oe_q;
    reg_addr_d = reg_addr_q;
    wr_data_d  = wr_data_q;
    wr_stb_d   = 1'b0;

    // Pointer advances the clk after each write strobe.
    if (wr_stb_q) begin
      reg_addr_d = reg_addr_q + 8'd1;
    end

    if (start_det) begin
      state_d  = StAddr;
      cnt_d    = 3'd0;
      sda_oe_d = 1'b0;
    end else if (stop_det) begin
      state_d  = StIdle;
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        StAddr: begin
          if (scl_rise) begin
            sr_d  = byte_in;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              rw_d    = byte_in[0];
              state_d = addr_match ? StAddrAck : StWaitStop;
            end
          end
        end

        // In the ACK states sda_oe doubles as the phase: the first SCL fall
        // starts the ACK bit, the second ends it.
        StAddrAck: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else if (rw_q) begin
              sr_d       = rd_data;
              sda_oe_d   = ~rd_data[7];
              reg_addr_d = reg_addr_q + 8'd1;
              cnt_d      = 3'd0;
              state_d    = StRdata;
            end else begin
              sda_oe_d = 1'b0;
              cnt_d    = 3'd0;
              state_d  = StPtr;
            end
          end
        end

        StPtr: begin
          if (scl_rise) begin
            sr_d  = byte_in;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              reg_addr_d = byte_in;
              state_d    = StPtrAck;
            end
          end
        end

        StPtrAck, StWdataAck: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              cnt_d    = 3'd0;
              state_d  = StWdata;
            end
          end
        end

        StWdata: begin
          if (scl_rise) begin
            sr_d  = byte_in;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              wr_stb_d  = 1'b1;
              wr_data_d = byte_in;
              state_d   = StWdataAck;
            end
          end
        end

        // Bit 7 was put on the bus by the fall that entered this state; each
        // further fall presents the next bit, the 8th fall releases SDA.
        StRdata: begin
          if (scl_fall) begin
            if (cnt_q == 3'd7) begin
              sda_oe_d = 1'b0;
              state_d  = StRdataAck;
            end else begin
              sr_d     = {sr_q[6:0], 1'b0};
              sda_oe_d = ~sr_q[6];
              cnt_d    = cnt_q + 3'd1;
            end
          end
        end

        // A fall can only be seen here after an ACK rise, since NACK leaves.
        StRdataAck: begin
          if (scl_rise && sda_s) begin
            state_d = StWaitStop;
          end else if (scl_fall) begin
            sr_d       = rd_data;
            sda_oe_d   = ~rd_data[7];
            reg_addr_d = reg_addr_q + 8'd1;
            cnt_d      = 3'd0;
            state_d    = StRdata;
          end
        end

        StIdle, StWaitStop: begin
          sda_oe_d = 1'b0;
        end

        default: begin
          state_d  = StIdle;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  assign sda_oe   = sda_oe_q;
  assign reg_addr = reg_addr_q;
  assign wr_data  = wr_data_q;
  assign wr_stb   = wr_stb_q;
  assign busy     = (state_q != StIdle) && (state_q != StAddr) && (state_q != StWaitStop);

endmodule
